mem_stage_sequencer: RTL and testbench
======================================

# mem_stage_sequencer

Memory-stage access sequencer for the pipelined LC-3b core. It reads the memory-stage fields of the control word latched in EX/MEM and issues one or two data-memory transactions per instruction: LDR/STR/LDB/STB take one, LDI/STI take two. While a transaction is in flight it stalls the pipeline. It returns the aligned and extended load data for write-back. It sits between the EX/MEM register and the data port of the L1 data cache.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ctrl_valid  in  1  EX/MEM holds a live instruction
- in_mem, in_ld, in_st, in_byte, in_indirect, in_sti  in  1 each  corresponding lc3b_control_word fields from EX/MEM
- ex_addr  in  16  effective address computed in EX
- ex_wdata  in  16  store source register value
- dmem_resp  in  1  data cache completion strobe, 1 cycle
- dmem_rdata  in  16  data cache read data, valid with dmem_resp
- dmem_read, dmem_write  out  1 each  request strobes, held until dmem_resp
- dmem_address  out  16  request address
- dmem_wdata  out  16  request write data
- dmem_byte_enable  out  2  lc3b_mem_wmask; bit1 is the high byte
- mdr_out  out  16  load result for MEM/WB
- done  out  1  one-cycle completion pulse
- stall  out  1  deasserts if_id/id_ex/ex_mem/mem_wb enables
- misalign  out  1  word-access misalignment flag (see Configuration)

## Operation
- Start condition: `go = ctrl_valid & in_mem`.
- States and transitions:
  - IDLE → ACC1 when `go`.
  - ACC1 → ACC2 on dmem_resp when in_indirect.
  - ACC1 → DONE on dmem_resp when not in_indirect.
  - ACC2 → DONE on dmem_resp.
  - DONE → IDLE unconditionally.
- ACC1, direct access:
  - Address is ex_addr. Word accesses force bit0 to 0; byte accesses use ex_addr as given.
  - dmem_read = in_ld, dmem_write = in_st.
- ACC1, indirect access:
  - Always a word read at {ex_addr[15:1],0}.
  - On dmem_resp the returned value is captured into the internal 16-bit register ptr.
- ACC2: word access at {ptr[15:1],0}.
  - LDI issues a read.
  - STI (in_sti) issues a write of ex_wdata.
- Byte enables:
  - Word access: 2'b11.
  - Byte access: 2'b10 if the address bit0 is 1, else 2'b01.
  - Indirect accesses ignore in_byte.
- Store data:
  - STB drives {ex_wdata[7:0], ex_wdata[7:0]}.
  - Word stores drive ex_wdata.
- Load result (mdr_out), captured on the final dmem_resp:
  - LDB: {8'h00, selected byte}, where bit0=1 selects dmem_rdata[15:8].
  - Word load: dmem_rdata.
  - Stores leave mdr_out unchanged.
- stall = `go & ~done`.
  - It is combinational, so it asserts in the same cycle the instruction arrives.
  - It is 0 in the DONE cycle, so the pipeline advances on that edge.
- dmem_resp is ignored in IDLE and DONE.
- dmem_read and dmem_write are never both 1.
- Reset values: all outputs 0, state IDLE, ptr 0.

## Timing
- All request outputs are registered; they change only on clock edges. done is registered (asserted while in DONE).
- Request rules:
  - The request rises on the edge after `go`.
  - address, wdata and byte enables stay stable until the edge after dmem_resp.
  - Strobes drop on the edge that samples dmem_resp.
- Latency from instruction arrival to done, with N = cycles from request to dmem_resp (minimum 1):
  - Single access: N+2 cycles.
  - Indirect access: N1+N2+3 cycles.
- Back-to-back memory instructions: DONE→IDLE→ACC1, which gives one bubble cycle between transactions.
- Asynchronous reset mid-transaction:
  - Strobes drop immediately.
  - The cache is required to accept an abandoned request.
  - No done pulse is issued.
- When `go` is low the block stays in IDLE with stall=0.

## Configuration
- MEM_SEQ_ALIGN_CHECK_EN defined:
  - A non-indirect word access with ex_addr[0]=1 issues no memory request.
  - It goes IDLE → DONE directly, pulses done with misalign=1 for that cycle, and leaves mdr_out unchanged.
  - The indirect ACC1 word read is checked the same way: with ex_addr[0]=1 it issues no request and ends as above.
  - In ACC2, ptr[0] is masked, not checked.
- MEM_SEQ_ALIGN_CHECK_EN undefined:
  - Bit0 is silently cleared and the access proceeds.
  - misalign is tied to 0.

## Test plan
- LDR at ex_addr=16'h3004, dmem_resp after 3 cycles, dmem_rdata=16'hBEEF:
  - One read at 16'h3004 with be=2'b11.
  - mdr_out=16'hBEEF; done pulses once.
  - stall is high from arrival until the DONE cycle.
- LDB at 16'h3005 with rdata=16'hA55A → mdr_out=16'h00A5. LDB at 16'h3004 with the same rdata → mdr_out=16'h005A.
- STB at 16'h2001 with ex_wdata=16'h12C3 → dmem_wdata=16'hC3C3, be=2'b10, dmem_write for exactly the request window.
- STI at 16'h4000, first read returns 16'h5002:
  - Read at 16'h4000, then write of ex_wdata at 16'h5002.
  - done follows the second dmem_resp; dmem_read and dmem_write never overlap.
- Reset asserted during the ACC2 of an LDI:
  - Outputs go to 0 asynchronously; state returns to IDLE.
  - No done pulse; a following LDR completes normally.
- With MEM_SEQ_ALIGN_CHECK_EN, LDR at 16'h3003:
  - No dmem_read ever rises.
  - done=misalign=1 for one cycle, 1 cycle after arrival.
  - Without the macro: read at 16'h3002 and misalign stays 0.

Source files
------------

// File: rtl/mem_stage_sequencer.sv
// LC-3b memory-stage sequencer: one data-cache access for LDR/STR/LDB/STB, two for LDI/STI.
// Optional word-alignment trap is enabled by defining MEM_SEQ_ALIGN_CHECK_EN.
module mem_stage_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_valid,
  input  logic        in_mem,
  input  logic        in_ld,
  input  logic        in_st,
  input  logic        in_byte,
  input  logic        in_indirect,
  input  logic        in_sti,
  input  logic [15:0] ex_addr,
  input  logic [15:0] ex_wdata,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] mdr_out,
  output logic        done,
  output logic        stall,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC1,
    S_ACC2,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_read;
  logic        r_write;
  logic [15:0] r_address;
  logic [15:0] r_wdata;
  logic [1:0]  r_be;
  logic [15:0] r_mdr;
  logic        r_done;
  logic [15:0] r_ptr;
  logic        r_indirect;
  logic        r_byteLoad;
  logic        r_acc2Issued;

  logic        w_go;
  logic        w_wordAcc;
  logic        w_misalignHit;
  logic [15:0] w_loadData;

  assign w_go      = ctrl_valid & in_mem;
  assign w_wordAcc = in_indirect | ~in_byte;

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  assign w_misalignHit = w_wordAcc & ex_addr[0];
`else
  assign w_misalignHit = 1'b0;
`endif

  // Byte loads pick the lane addressed by bit0 and zero-extend it.
  assign w_loadData = r_byteLoad
                      ? (r_address[0] ? {8'h00, dmem_rdata[15:8]} : {8'h00, dmem_rdata[7:0]})
                      : dmem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_nextState = w_misalignHit ? S_DONE : S_ACC1;
        end
      end
      S_ACC1: begin
        if (dmem_resp) begin
          w_nextState = r_indirect ? S_ACC2 : S_DONE;
        end
      end
      S_ACC2: begin
        if (r_acc2Issued && dmem_resp) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // ACC2 spends its first cycle loading the request from the captured pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= 16'h0000;
      r_wdata      <= 16'h0000;
      r_be         <= 2'b00;
      r_mdr        <= 16'h0000;
      r_done       <= 1'b0;
      r_ptr        <= 16'h0000;
      r_indirect   <= 1'b0;
      r_byteLoad   <= 1'b0;
      r_acc2Issued <= 1'b0;
    end else begin
      r_done <= (w_nextState == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_go && !w_misalignHit) begin
            r_read       <= in_indirect | in_ld;
            r_write      <= ~in_indirect & ~in_ld & in_st;
            r_address    <= w_wordAcc ? {ex_addr[15:1], 1'b0} : ex_addr;
            r_wdata      <= (in_byte && !in_indirect) ? {ex_wdata[7:0], ex_wdata[7:0]} : ex_wdata;
            r_be         <= w_wordAcc ? 2'b11 : (ex_addr[0] ? 2'b10 : 2'b01);
            r_byteLoad   <= ~in_indirect & in_byte;
            r_indirect   <= in_indirect;
            r_acc2Issued <= 1'b0;
          end
        end
        S_ACC1: begin
          if (dmem_resp) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_indirect) begin
              r_ptr <= dmem_rdata;
            end else if (r_read) begin
              r_mdr <= w_loadData;
            end
          end
        end
        S_ACC2: begin
          if (!r_acc2Issued) begin
            r_read       <= ~in_sti;
            r_write      <= in_sti;
            r_address    <= {r_ptr[15:1], 1'b0};
            r_wdata      <= ex_wdata;
            r_be         <= 2'b11;
            r_byteLoad   <= 1'b0;
            r_acc2Issued <= 1'b1;
          end else if (dmem_resp) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_read) begin
              r_mdr <= dmem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (r_state == S_IDLE) && w_go && w_misalignHit;
    end
  end

  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  assign dmem_read        = r_read;
  assign dmem_write       = r_write;
  assign dmem_address     = r_address;
  assign dmem_wdata       = r_wdata;
  assign dmem_byte_enable = r_be;
  assign mdr_out          = r_mdr;
  assign done             = r_done;
  assign stall            = w_go & ~r_done;

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Bench for mem_stage_sequencer: directed cases plus random instructions against a cycle-schedule model.
// Honours MEM_SEQ_ALIGN_CHECK_EN the same way as the design.
module tb_mem_stage_sequencer;

  localparam int K_LDR = 0;
  localparam int K_STR = 1;
  localparam int K_LDB = 2;
  localparam int K_STB = 3;
  localparam int K_LDI = 4;
  localparam int K_STI = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_valid, in_mem, in_ld, in_st, in_byte, in_indirect, in_sti;
  logic [15:0] ex_addr, ex_wdata;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_address, dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] mdr_out;
  logic        done, stall, misalign;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] expMdr;

  always #5 clk = ~clk;

  mem_stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(ctrl_valid), .in_mem(in_mem),
    .in_ld(in_ld), .in_st(in_st), .in_byte(in_byte), .in_indirect(in_indirect),
    .in_sti(in_sti), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .mdr_out(mdr_out), .done(done), .stall(stall), .misalign(misalign)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Entered just after a rising edge with the block idle; returns one cycle after done.
  // Cycle 0 is arrival; access k occupies cycles [start,end] where end-start+1 = its latency.
  task automatic applyStimulus(input int kind, input logic [15:0] addr, input logic [15:0] wd,
                               input int n1, input int n2, input logic [15:0] rd1,
                               input logic [15:0] rd2, input logic junkByte);
    logic        isInd, isLoad, isByte, wordAcc, misHit, r1, w1, r2, w2, in1, in2;
    logic [15:0] a1, a2, wd1;
    logic [1:0]  be1, expRW;
    int          w1s, w1e, w2s, w2e, dCyc;
    isInd   = (kind == K_LDI) || (kind == K_STI);
    isLoad  = (kind == K_LDR) || (kind == K_LDB) || (kind == K_LDI);
    isByte  = (kind == K_LDB) || (kind == K_STB);
    wordAcc = !isByte;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    misHit  = wordAcc && addr[0];
`else
    misHit  = 1'b0;
`endif
    a1  = wordAcc ? (addr & 16'hFFFE) : addr;
    be1 = wordAcc ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
    r1  = isInd || isLoad;
    w1  = !r1;
    wd1 = isByte ? {wd[7:0], wd[7:0]} : wd;
    a2  = rd1 & 16'hFFFE;
    r2  = isLoad;
    w2  = !isLoad;
    w1s = -5; w1e = -5; w2s = -5; w2e = -5;
    if (misHit) begin
      dCyc = 1;
    end else if (isInd) begin
      w1s = 1; w1e = n1; w2s = n1 + 2; w2e = n1 + n2 + 1; dCyc = n1 + n2 + 2;
      if (kind == K_LDI) expMdr = rd2;
    end else begin
      w1s = 1; w1e = n1; dCyc = n1 + 1;
      if (kind == K_LDR) expMdr = rd1;
      else if (kind == K_LDB) expMdr = addr[0] ? {8'h00, rd1[15:8]} : {8'h00, rd1[7:0]};
    end

    ctrl_valid = 1'b1; in_mem = 1'b1; in_ld = isLoad; in_st = !isLoad;
    in_byte = isInd ? junkByte : isByte; in_indirect = isInd; in_sti = (kind == K_STI);
    ex_addr = addr; ex_wdata = wd; dmem_resp = 1'b0;
    #1;
    checkOutput("arrivalStall", {15'd0, stall}, 16'd1);
    checkOutput("arrivalStrobes", {14'd0, dmem_read, dmem_write}, 16'd0);

    for (int c = 1; c <= dCyc; c++) begin
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      in1 = (c >= w1s) && (c <= w1e);
      in2 = (c >= w2s) && (c <= w2e);
      expRW = in1 ? {r1, w1} : (in2 ? {r2, w2} : 2'b00);
      checkOutput("strobes", {14'd0, dmem_read, dmem_write}, {14'd0, expRW});
      if (in1) begin
        checkOutput("addr1", dmem_address, a1);
        checkOutput("be1", {14'd0, dmem_byte_enable}, {14'd0, be1});
        if (w1) checkOutput("wdata1", dmem_wdata, wd1);
      end
      if (in2) begin
        checkOutput("addr2", dmem_address, a2);
        checkOutput("be2", {14'd0, dmem_byte_enable}, 16'h0003);
        if (w2) checkOutput("wdata2", dmem_wdata, wd);
      end
      checkOutput("done", {15'd0, done}, {15'd0, c == dCyc});
      checkOutput("stall", {15'd0, stall}, {15'd0, c != dCyc});
      if (c == dCyc) begin
        checkOutput("mdr", mdr_out, expMdr);
        checkOutput("misalign", {15'd0, misalign}, {15'd0, misHit});
        dmem_resp  = 1'(($urandom % 2));
        dmem_rdata = 16'($urandom);
      end else if (c == w1e) begin
        dmem_resp = 1'b1; dmem_rdata = rd1;
      end else if (c == w2e) begin
        dmem_resp = 1'b1; dmem_rdata = rd2;
      end else begin
        dmem_rdata = 16'($urandom);
      end
    end

    @(posedge clk); #1;
    dmem_resp = 1'b0; ctrl_valid = 1'b0; in_mem = 1'b0;
    checkOutput("donePulse", {15'd0, done}, 16'd0);
    checkOutput("postStrobes", {14'd0, dmem_read, dmem_write}, 16'd0);
    checkOutput("postMdr", mdr_out, expMdr);
  endtask

  initial begin
    rst_n = 1'b0; ctrl_valid = 1'b0; in_mem = 1'b0; in_ld = 1'b0; in_st = 1'b0;
    in_byte = 1'b0; in_indirect = 1'b0; in_sti = 1'b0; ex_addr = 16'h0; ex_wdata = 16'h0;
    dmem_resp = 1'b0; dmem_rdata = 16'h0; expMdr = 16'h0;
    #12;
    checkOutput("rstRead", {15'd0, dmem_read}, 16'd0);
    checkOutput("rstWrite", {15'd0, dmem_write}, 16'd0);
    checkOutput("rstAddr", dmem_address, 16'd0);
    checkOutput("rstMdr", mdr_out, 16'd0);
    checkOutput("rstDone", {15'd0, done}, 16'd0);
    checkOutput("rstStall", {15'd0, stall}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(K_LDR, 16'h3004, 16'h0000, 3, 1, 16'hBEEF, 16'h0000, 1'b0);
    applyStimulus(K_LDB, 16'h3005, 16'h0000, 1, 1, 16'hA55A, 16'h0000, 1'b0);
    applyStimulus(K_LDB, 16'h3004, 16'h0000, 2, 1, 16'hA55A, 16'h0000, 1'b0);
    applyStimulus(K_STB, 16'h2001, 16'h12C3, 2, 1, 16'h0000, 16'h0000, 1'b0);
    applyStimulus(K_STI, 16'h4000, 16'h9876, 2, 3, 16'h5002, 16'h0000, 1'b1);
    applyStimulus(K_LDI, 16'h4001, 16'h0000, 1, 1, 16'h5003, 16'h1357, 1'b0);

    // LDI interrupted by reset while its second access is outstanding.
    ctrl_valid = 1'b1; in_mem = 1'b1; in_ld = 1'b1; in_st = 1'b0; in_byte = 1'b0;
    in_indirect = 1'b1; in_sti = 1'b0; ex_addr = 16'h6000; ex_wdata = 16'h1111;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      dmem_resp = (c == 2); dmem_rdata = 16'h7000;
    end
    checkOutput("rstPreRead", {15'd0, dmem_read}, 16'd1);
    checkOutput("rstPreAddr", dmem_address, 16'h7000);
    #2; rst_n = 1'b0; #1;
    checkOutput("midRstRead", {15'd0, dmem_read}, 16'd0);
    checkOutput("midRstAddr", dmem_address, 16'd0);
    checkOutput("midRstBe", {14'd0, dmem_byte_enable}, 16'd0);
    checkOutput("midRstMdr", mdr_out, 16'd0);
    @(posedge clk); #1;
    checkOutput("midRstNoDone", {15'd0, done}, 16'd0);
    ctrl_valid = 1'b0; in_mem = 1'b0; rst_n = 1'b1; expMdr = 16'h0;
    @(posedge clk); #1;
    checkOutput("postRstNoDone", {15'd0, done}, 16'd0);
    applyStimulus(K_LDR, 16'h3008, 16'h0000, 2, 1, 16'h4242, 16'h0000, 1'b0);

    // Odd word address: trapped with the alignment check, silently aligned otherwise.
    applyStimulus(K_LDR, 16'h3003, 16'h0000, 2, 1, 16'hCAFE, 16'h0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        ctrl_valid = 1'(($urandom % 2)); in_mem = ~ctrl_valid;
        dmem_resp = 1'(($urandom % 2)); dmem_rdata = 16'($urandom);
        #1;
        checkOutput("idleStall", {15'd0, stall}, 16'd0);
        checkOutput("idleStrobes", {14'd0, dmem_read, dmem_write}, 16'd0);
        checkOutput("idleDone", {15'd0, done}, 16'd0);
        @(posedge clk); #1;
        ctrl_valid = 1'b0; in_mem = 1'b0; dmem_resp = 1'b0;
      end
      applyStimulus($urandom_range(0, 5), 16'($urandom), 16'($urandom),
                    $urandom_range(1, 4), $urandom_range(1, 4),
                    16'($urandom), 16'($urandom), 1'(($urandom % 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
